// File: rtl/shifter_operand_ctrl.sv
// ARM data-processing shifter operand controller: a decode register
// feeding a 32-bit rotator plus fill/carry logic, with valid/ready flow.

module barrel_shifter (
  input  logic [31:0] data,
  input  logic [4:0]  amt,
  input  logic        left,
  output logic [31:0] y
);
  logic [5:0]  k;
  logic [63:0] w;

  // left by n == right by 32-n; k==32 yields the input unchanged
  always_comb begin
    k = left ? (6'd32 - {1'b0, amt}) : {1'b0, amt};
    w = {data, data} >> k;
    y = w[31:0];
  end
endmodule

module shifter_operand_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_type,
  input  logic [7:0]  req_amt,
  input  logic        req_imm,
  input  logic        carry_in,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_carry,
  output logic        busy
);
  localparam logic [2:0] F_NONE = 3'd0;
  localparam logic [2:0] F_ZERO = 3'd1;
  localparam logic [2:0] F_SIGN = 3'd2;
  localparam logic [2:0] F_RRX  = 3'd3;
  localparam logic [2:0] F_PASS = 3'd4;
  localparam logic [2:0] F_ZALL = 3'd5;
  localparam logic [2:0] F_SALL = 3'd6;

  localparam logic [2:0] C_ROT  = 3'd0;
  localparam logic [2:0] C_D31  = 3'd1;
  localparam logic [2:0] C_D0   = 3'd2;
  localparam logic [2:0] C_CIN  = 3'd3;
  localparam logic [2:0] C_ZERO = 3'd4;

  logic        d_left;
  logic [2:0]  d_fill;
  logic [2:0]  d_csrc;
  logic        z5;
  logic        eq32;
  logic        ge32;

  logic        s1_valid;
  logic [31:0] s1_data;
  logic        s1_cin;
  logic [4:0]  s1_amt;
  logic        s1_left;
  logic [2:0]  s1_fill;
  logic [2:0]  s1_csrc;

  logic [31:0] rot;
  logic [31:0] mask;
  logic [31:0] res;
  logic        cout;
  logic        adv;
  logic        acc;

  assign z5   = (req_amt[4:0] == 5'd0);
  assign eq32 = (req_amt == 8'd32);
  assign ge32 = |req_amt[7:5];

  // 32 and beyond never reach the rotator; fill/carry codes cover them
  always_comb begin
    d_left = (req_type == 2'b00);
    d_fill = F_NONE;
    d_csrc = C_ROT;
    if (req_imm) begin
      unique case (req_type)
        2'b00: begin
          d_fill = z5 ? F_PASS : F_ZERO;
          d_csrc = z5 ? C_CIN : C_ROT;
        end
        2'b01: begin
          d_fill = z5 ? F_ZALL : F_ZERO;
          d_csrc = z5 ? C_D31 : C_ROT;
        end
        2'b10: begin
          d_fill = z5 ? F_SALL : F_SIGN;
          d_csrc = z5 ? C_D31 : C_ROT;
        end
        default: begin
          d_fill = z5 ? F_RRX : F_NONE;
          d_csrc = z5 ? C_D0 : C_ROT;
        end
      endcase
    end else if (req_amt == 8'd0) begin
      d_fill = F_PASS;
      d_csrc = C_CIN;
    end else begin
      unique case (req_type)
        2'b00: begin
          d_fill = ge32 ? F_ZALL : F_ZERO;
          d_csrc = !ge32 ? C_ROT :
                   eq32 ? C_D0 : C_ZERO;
        end
        2'b01: begin
          d_fill = ge32 ? F_ZALL : F_ZERO;
          d_csrc = !ge32 ? C_ROT :
                   eq32 ? C_D31 : C_ZERO;
        end
        2'b10: begin
          d_fill = ge32 ? F_SALL : F_SIGN;
          d_csrc = ge32 ? C_D31 : C_ROT;
        end
        default: begin
          d_fill = z5 ? F_PASS : F_NONE;
          d_csrc = z5 ? C_D31 : C_ROT;
        end
      endcase
    end
  end

  barrel_shifter u_rot (
    .data (s1_data),
    .amt  (s1_amt),
    .left (s1_left),
    .y    (rot)
  );

  always_comb begin
    mask = s1_left ? ((32'd1 << s1_amt) - 32'd1)
                   : ~(32'hFFFF_FFFF >> s1_amt);
    unique case (s1_fill)
      F_ZERO:  res = rot & ~mask;
      F_SIGN:  res = (rot & ~mask)
                   | (mask & {32{s1_data[31]}});
      F_RRX:   res = {s1_cin, s1_data[31:1]};
      F_PASS:  res = s1_data;
      F_ZALL:  res = 32'd0;
      F_SALL:  res = {32{s1_data[31]}};
      default: res = rot;
    endcase
    unique case (s1_csrc)
      C_ROT:   cout = s1_left ? rot[0] : rot[31];
      C_D31:   cout = s1_data[31];
      C_D0:    cout = s1_data[0];
      C_CIN:   cout = s1_cin;
      default: cout = 1'b0;
    endcase
  end

  assign adv       = !rsp_valid | rsp_ready;
  assign req_ready = !s1_valid | adv;
  assign acc       = req_valid & req_ready;
  assign busy      = s1_valid | rsp_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_data   <= 32'd0;
      s1_cin    <= 1'b0;
      s1_amt    <= 5'd0;
      s1_left   <= 1'b0;
      s1_fill   <= F_NONE;
      s1_csrc   <= C_ROT;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
      rsp_carry <= 1'b0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      if (adv) begin
        rsp_valid <= s1_valid;
        if (s1_valid) begin
          rsp_data  <= res;
          rsp_carry <= cout;
        end
      end
      if (acc) begin
        s1_valid <= 1'b1;
        s1_data  <= req_data;
        s1_cin   <= carry_in;
        s1_amt   <= req_amt[4:0];
        s1_left  <= d_left;
        s1_fill  <= d_fill;
        s1_csrc  <= d_csrc;
      end else if (adv) begin
        s1_valid <= 1'b0;
      end
    end
  end
endmodule
